fifo_sync_flags: RTL and testbench

Synchronous single-clock FIFO, the parametrised successor to the basic sync FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time first-word-fall-through (FWFT) read mode is also available. It sits between a streaming producer and consumer in the same clock domain, and status flags drive upstream back-pressure.

---
 rtl/fifo_sync_flags.sv | 113 +++++++++++
 tb/tb_fifo_sync_flags.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module fifo_sync_flags #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_BITS     = 4,
    parameter int unsigned AFULL_THRESH  = 2**ADDR_BITS - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW    = ADDR_BITS + 1;
    localparam int unsigned DEPTH = 2**ADDR_BITS;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    generate
        if (ADDR_BITS < 1 || AFULL_THRESH == 0 || AFULL_THRESH > DEPTH ||
            AEMPTY_THRESH >= DEPTH) begin : g_bad_params
            $error("fifo_sync_flags: illegal ADDR_BITS/AFULL_THRESH/AEMPTY_THRESH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] w_ptr_reg, r_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          empty_reg, full_reg, aempty_reg, afull_reg;
    logic          ovf_reg, udf_reg;
    logic          wr_acc, rd_acc;

    // Acceptance is judged from the registered flags, so at full a read wins
    // and at empty a write wins without extra arbitration.
    assign wr_acc     = w_en && !full_reg;
    assign rd_acc     = r_en && !empty_reg;
    assign count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            w_ptr_reg  <= '0;
            r_ptr_reg  <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            aempty_reg <= 1'b1;
            afull_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            if (wr_acc)
                w_ptr_reg <= w_ptr_reg + CW'(1);
            if (rd_acc)
                r_ptr_reg <= r_ptr_reg + CW'(1);
            count_reg  <= count_next;
            empty_reg  <= (count_next == '0);
            full_reg   <= (count_next == DEPTH_C);
            aempty_reg <= (count_next <= AEMPTY_C);
            afull_reg  <= (count_next >= AFULL_C);
            // A new error in the same cycle as err_clr stays visible.
            if (w_en && full_reg)
                ovf_reg <= 1'b1;
            else if (err_clr)
                ovf_reg <= 1'b0;
            if (r_en && empty_reg)
                udf_reg <= 1'b1;
            else if (err_clr)
                udf_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc)
            mem[w_ptr_reg[ADDR_BITS-1:0]] <= data_in;
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign data_out = empty_reg ? '0 : mem[r_ptr_reg[ADDR_BITS-1:0]];
`else
    logic [DATA_WIDTH-1:0] dout_reg;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)
            dout_reg <= '0;
        else if (rd_acc)
            dout_reg <= mem[r_ptr_reg[ADDR_BITS-1:0]];
    end

    assign data_out = dout_reg;
`endif

    assign fifo_empty   = empty_reg;
    assign fifo_full    = full_reg;
    assign almost_empty = aempty_reg;
    assign almost_full  = afull_reg;
    assign fill_count   = count_reg;
    assign overflow     = ovf_reg;
    assign underflow    = udf_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: queue-based reference model checked every cycle,
// directed walk through fill/drain/wrap/error/reset cases, then random traffic.
module tb_fifo_sync_flags;

    localparam int DW    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic          clk_i    = 1'b0;
    logic          resetn_i = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic          w_en     = 1'b0;
    logic          r_en     = 1'b0;
    logic          err_clr  = 1'b0;
    logic [DW-1:0] data_out;
    logic          fifo_empty, fifo_full, almost_empty, almost_full;
    logic [AB:0]   fill_count;
    logic          overflow, underflow;

    fifo_sync_flags #(
        .DATA_WIDTH   (DW),
        .ADDR_BITS    (AB),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .data_in     (data_in),
        .w_en        (w_en),
        .r_en        (r_en),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .fill_count  (fill_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of stored words plus the two sticky flags.
    logic [DW-1:0] q[$];
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;
    logic [DW-1:0] m_dout = '0;
    bit            m_wok, m_rok;

    always @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dout = '0;
        end else begin
            m_wok = w_en && (q.size() < DEPTH);
            m_rok = r_en && (q.size() > 0);
            if (w_en && q.size() == DEPTH) m_ovf = 1'b1;
            else if (err_clr)               m_ovf = 1'b0;
            if (r_en && q.size() == 0)      m_udf = 1'b1;
            else if (err_clr)               m_udf = 1'b0;
            if (m_rok) m_dout = q.pop_front();
            if (m_wok) q.push_back(data_in);
        end
    end

    function automatic logic [DW-1:0] model_dout();
`ifdef FIFO_SYNC_FWFT_EN
        return (q.size() > 0) ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    always @(negedge clk_i) begin
        check("fill_count",   32'(fill_count),   32'(q.size()));
        check("fifo_empty",   32'(fifo_empty),   32'(q.size() == 0));
        check("fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AET));
        check("almost_full",  32'(almost_full),  32'(q.size() >= AFT));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("data_out",     32'(data_out),     32'(model_dout()));
    end

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        w_en    = w;
        r_en    = r;
        data_in = d;
        err_clr = c;
        @(posedge clk_i);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"},  32'(fifo_empty),   32'd1);
        check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        check({tag, "_full"},   32'(fifo_full),    32'd0);
        check({tag, "_afull"},  32'(almost_full),  32'd0);
        check({tag, "_count"},  32'(fill_count),   32'd0);
        check({tag, "_ovf"},    32'(overflow),     32'd0);
        check({tag, "_udf"},    32'(underflow),    32'd0);
        check({tag, "_dout"},   32'(data_out),     32'd0);
    endtask

    initial begin
        #22;
        resetn_i = 1'b1;
        check_reset_values("rst");

        // Fill 0x01..0x10 with no reads.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, DW'(i), 1'b0);
            check("fill_step",   32'(fill_count),   32'(i));
            check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
            check("fill_afull",  32'(almost_full),  32'(i >= 14));
            check("fill_full",   32'(fifo_full),    32'(i == 16));
            check("fill_ovf",    32'(overflow),     32'd0);
        end

        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        check("ovf_set",   32'(overflow),   32'd1);
        check("ovf_count", 32'(fill_count), 32'd16);

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
            check("drain_data", 32'(data_out), 32'(i));
            cyc(1'b0, 1'b1, '0, 1'b0);
`else
            cyc(1'b0, 1'b1, '0, 1'b0);
            check("drain_data", 32'(data_out), 32'(i));
`endif
        end
        check("drain_empty", 32'(fifo_empty), 32'd1);

        cyc(1'b0, 1'b1, '0, 1'b0);
        check("udf_set", 32'(underflow), 32'd1);
`ifdef FIFO_SYNC_FWFT_EN
        check("udf_dout", 32'(data_out), 32'd0);
`else
        check("udf_dout", 32'(data_out), 32'h10);
`endif
        cyc(1'b0, 1'b0, '0, 1'b1);
        check("clr_udf", 32'(underflow), 32'd0);
        check("clr_ovf", 32'(overflow),  32'd0);

        // Steady state at 5 words with simultaneous read/write across the wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
`ifdef FIFO_SYNC_FWFT_EN
            check("stream_data", 32'(data_out), 32'(8'h20 + k));
            cyc(1'b1, 1'b1, DW'(8'h25 + k), 1'b0);
`else
            cyc(1'b1, 1'b1, DW'(8'h25 + k), 1'b0);
            check("stream_data", 32'(data_out), 32'(8'h20 + k));
`endif
            check("stream_count", 32'(fill_count), 32'd5);
        end
        check("stream_ovf", 32'(overflow),  32'd0);
        check("stream_udf", 32'(underflow), 32'd0);

        // Top up to full, then read+write together: only the read goes through.
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
        check("topup_full", 32'(fifo_full), 32'd1);
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        check("full_rw_count", 32'(fill_count), 32'd15);
        check("full_rw_ovf",   32'(overflow),   32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, '0, 1'b0);
        check("pre_rst_count", 32'(fill_count), 32'd9);
        #2;
        resetn_i = 1'b0;
        #1;
        check_reset_values("async");
        #3;
        resetn_i = 1'b1;

        cyc(1'b1, 1'b0, 8'hA5, 1'b0);
        check("a5_count", 32'(fill_count), 32'd1);
`ifdef FIFO_SYNC_FWFT_EN
        check("a5_data", 32'(data_out), 32'hA5);
        cyc(1'b0, 1'b1, '0, 1'b0);
`else
        cyc(1'b0, 1'b1, '0, 1'b0);
        check("a5_data", 32'(data_out), 32'hA5);
`endif

        // Random traffic with varying read/write bias and one mid-run reset.
        for (int blk = 0; blk < 10; blk++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            if (blk == 5) begin
                #2;
                resetn_i = 1'b0;
                #1;
                check("rand_rst_count", 32'(fill_count), 32'd0);
                #4;
                resetn_i = 1'b1;
            end
            for (int c = 0; c < 200; c++) begin
                cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                    DW'($urandom_range(0, 255)), ($urandom_range(0, 31) == 0));
            end
        end

        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
